// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the byte / byte-counter widths used on the UART side.
package uart_arb_pkg;

    localparam int UART_BYTE_W  = 8;
    localparam int BYTES_SENT_W = 16;

    // IDLE: no owner; SEND: owner holds the grant, waiting to issue a byte;
    // WAIT_DONE: byte strobed, waiting for the UART to report busy.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Searches the request vector
// starting one position above the pointer, wrapping, and returns a one-hot
// grant plus a found flag. Implemented as rotate / isolate-lowest / rotate
// back so it stays a flat expression for any N.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             found
);

    localparam logic [PTR_W:0] N_W = (PTR_W + 1)'(N);

    logic [PTR_W:0] start;      // rotation amount ptr+1, always in 1..N
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;    // bit k = requester (ptr+1+k) mod N
    logic [N-1:0]   low;        // lowest set bit of req_rot
    logic [2*N-1:0] low_dbl;

    assign start   = {1'b0, ptr} + (PTR_W + 1)'(1);
    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> start);
    assign low     = req_rot & (~req_rot + N'(1));
    assign low_dbl = {low, low};
    // Rotate left by start: the doubled vector shifted right by N-start.
    assign gnt     = N'(low_dbl >> (N_W - start));
    assign found   = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART byte transmitter between N_REQ record
// producers. Ownership changes only at record boundaries (round-robin), so
// bytes of different records never interleave.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a byte whose UART
// never reports busy within TIMEOUT cycles (sets sticky timeout_err).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ack,
    output logic [N_REQ-1:0]            grant,
    input  logic                        uart_ready,
    output logic [UART_BYTE_W-1:0]      uart_data,
    output logic                        uart_clock_enable,
    output logic                        busy,
    output logic [BYTES_SENT_W-1:0]     bytes_sent,
    output logic                        timeout_err
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_t               state_reg, state_next;
    logic [N_REQ-1:0]         grant_reg, grant_next;
    logic [N_REQ-1:0]         ack_reg, ack_next;
    logic [UART_BYTE_W-1:0]   data_reg, data_next;
    logic                     ce_reg, ce_next;
    logic                     busy_reg, busy_next;
    logic [BYTES_SENT_W-1:0]  bytes_sent_reg, bytes_sent_next;
    logic [PTR_W-1:0]         ptr_reg, ptr_next;
    logic                     last_reg, last_next;

    logic [N_REQ-1:0]         pick_gnt;
    logic                     pick_found;
    logic                     owner_valid;
    logic                     owner_last;
    logic [UART_BYTE_W-1:0]   owner_data;
    logic [PTR_W-1:0]         owner_idx;
    logic                     issue;
    logic                     to_expire;

    // Requests of non-owners are only looked at while idle.
    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    // One-hot grant selects the owner's byte and encodes its index; built as
    // OR chains so every lane is a plain AND-mask.
    logic [UART_BYTE_W-1:0] data_chain [N_REQ+1];
    logic [PTR_W-1:0]       idx_chain  [N_REQ+1];
    assign data_chain[0] = '0;
    assign idx_chain[0]  = '0;
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_owner
        assign data_chain[gi+1] = data_chain[gi]
            | (req_data[gi*UART_BYTE_W +: UART_BYTE_W] & {UART_BYTE_W{grant_reg[gi]}});
        assign idx_chain[gi+1]  = idx_chain[gi]
            | (grant_reg[gi] ? PTR_W'(gi) : '0);
    end
    assign owner_data  = data_chain[N_REQ];
    assign owner_idx   = idx_chain[N_REQ];
    assign owner_valid = |(req_valid & grant_reg);
    assign owner_last  = |(req_last & grant_reg);
    assign issue       = (state_reg == SEND) && uart_ready && owner_valid;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            err_reg, err_next;

    assign to_expire = (state_reg == WAIT_DONE) && uart_ready
                       && (to_cnt_reg == TO_W'(TIMEOUT - 1));

    // Watchdog: cycles spent in WAIT_DONE with the UART still idle.
    always_comb begin
        to_cnt_next = to_cnt_reg;
        err_next    = err_reg | to_expire;
        if (issue)
            to_cnt_next = '0;
        else if (state_reg == WAIT_DONE && uart_ready)
            to_cnt_next = to_cnt_reg + TO_W'(1);
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            to_cnt_reg <= to_cnt_next;
            err_reg    <= err_next;
        end
    end

    assign timeout_err = err_reg;
`else
    assign to_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (pick_found) state_next = SEND;
            SEND:      if (issue) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (!uart_ready)
                    state_next = last_reg ? IDLE : SEND;
                else if (to_expire)
                    state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    // Output / datapath next values; everything is registered below.
    always_comb begin
        grant_next      = grant_reg;
        ack_next        = '0;
        data_next       = data_reg;
        ce_next         = ce_reg;
        busy_next       = busy_reg;
        bytes_sent_next = bytes_sent_reg;
        ptr_next        = ptr_reg;
        last_next       = last_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_gnt;
                    busy_next  = 1'b1;
                end
            end
            SEND: begin
                if (issue) begin
                    data_next       = owner_data;
                    ce_next         = 1'b1;
                    ack_next        = grant_reg;
                    last_next       = owner_last;
                    bytes_sent_next = bytes_sent_reg + BYTES_SENT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!uart_ready) begin
                    ce_next = 1'b0;
                    if (last_reg) begin
                        ptr_next   = owner_idx;
                        grant_next = '0;
                        busy_next  = 1'b0;
                    end
                end else if (to_expire) begin
                    ce_next    = 1'b0;
                    ptr_next   = owner_idx;
                    grant_next = '0;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                grant_next = '0;
                ce_next    = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Registered outputs and record bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_reg      <= '0;
            ack_reg        <= '0;
            data_reg       <= '0;
            ce_reg         <= 1'b0;
            busy_reg       <= 1'b0;
            bytes_sent_reg <= '0;
            ptr_reg        <= PTR_W'(N_REQ - 1);
            last_reg       <= 1'b0;
        end else begin
            grant_reg      <= grant_next;
            ack_reg        <= ack_next;
            data_reg       <= data_next;
            ce_reg         <= ce_next;
            busy_reg       <= busy_next;
            bytes_sent_reg <= bytes_sent_next;
            ptr_reg        <= ptr_next;
            last_reg       <= last_next;
        end
    end

    assign grant             = grant_reg;
    assign req_ack           = ack_reg;
    assign uart_data         = data_reg;
    assign uart_clock_enable = ce_reg;
    assign busy              = busy_reg;
    assign bytes_sent        = bytes_sent_reg;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART byte transmitter between several record producers: the 48-bit capture serializer and the status/diagnostic reporter. Grants are round-robin at record (frame) boundaries, so bytes of different records never interleave on the serial line. Sits between the producers and the UART; it drives the UART's `uart_data` / `uart_clock_enable` / `uart_ready` handshake on their behalf.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters (2..8).
- `TIMEOUT`, default 1023: max cycles to wait for `uart_ready` to fall after a byte is issued (used only with the macro).

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  N_REQ  requester i has a byte available.
- `req_data`  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- `req_last`  in  N_REQ  byte of requester i is the last of its record.
- `req_ack`  out  N_REQ  one-cycle pulse: byte of requester i consumed.
- `grant`  out  N_REQ  one-hot current owner; 0 when idle.
- `uart_ready`  in  1  high = UART idle, can take a byte.
- `uart_data`  out  8  byte to UART.
- `uart_clock_enable`  out  1  byte strobe to UART.
- `busy`  out  1  high while any record is in progress.
- `bytes_sent`  out  16  count of bytes issued; wraps at 65535 -> 0.
- `timeout_err`  out  1  sticky; set on watchdog abort (macro only; else tied 0).

## Operation
- Reset values: `grant`=0, `req_ack`=0, `uart_data`=0, `uart_clock_enable`=0, `busy`=0, `bytes_sent`=0, `timeout_err`=0, round-robin pointer=N_REQ-1, state=IDLE.
- States: IDLE, SEND, WAIT_DONE.
- IDLE: if any `req_valid`, select first requester searching from pointer+1 upward, wrapping mod N_REQ; set `grant`, `busy`=1, -> SEND. None valid: stay.
- SEND: when `uart_ready` and `req_valid[g]`: `uart_data`<=byte g, `uart_clock_enable`<=1, `req_ack[g]`<=1 (one cycle), latch `req_last[g]`, `bytes_sent`+=1, -> WAIT_DONE. If `req_valid[g]` low mid-record: hold grant, wait indefinitely; other requesters are not served.
- WAIT_DONE: when `uart_ready`=0: `uart_clock_enable`<=0; if latched last: pointer<=g, `grant`<=0, `busy`<=0, -> IDLE; else -> SEND.
- Requesters must present the next byte only after seeing `req_ack`; data and last are sampled in the same cycle as the ack is issued.
- `req_valid` of non-granted requesters is ignored; deasserting it while not granted is legal.
- Reset mid-record: frame abandoned, all outputs to reset values on the next edge; no partial byte re-sent.

## Timing
- IDLE -> SEND: 1 cycle after `req_valid` seen. SEND -> byte strobe: same edge `uart_ready` and valid are both high.
- Min per-byte cost: 2 cycles plus UART busy time; back-to-back records from different requesters have 1 IDLE cycle between them.
- `uart_clock_enable` stays high from issue until the first cycle `uart_ready` is low (inclusive of that edge's update).
- Simultaneous requests at IDLE: rotation decides; requester just served is lowest priority.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined: WAIT_DONE counts cycles; if `uart_ready` still high after TIMEOUT cycles, drop `uart_clock_enable`, set `timeout_err` (sticky until reset), release grant (pointer<=g), -> IDLE. Remaining bytes of that record are then arbitrated as a new record.
- Undefined: no counter; WAIT_DONE waits indefinitely; `timeout_err` constant 0.

## Structure
- Shared package `uart_arb_pkg`: state enum, `UART_BYTE_W`=8, `BYTES_SENT_W`=16.
- One sub-module: `rr_pick` — combinational round-robin selector (request vector, pointer -> one-hot grant, found flag).

## Test plan
- Single requester 0 sends record 0xA5,0x5A (last on 2nd) with model UART: 2 strobes, `uart_data` 0xA5 then 0x5A, two `req_ack[0]` pulses, `bytes_sent`=2, back to IDLE, `grant`=0.
- Requesters 0 and 1 both valid from reset, 3-byte records: order 0,0,0,1,1,1; next contention round 0 first again (pointer=1).
- Requester 1 drops valid mid-record for 20 cycles while requester 0 is valid: no byte from 0 issued; grant stays 1-hot on 1.
- Reset asserted in WAIT_DONE: next cycle `uart_clock_enable`=0, `grant`=0, `bytes_sent`=0.
- `bytes_sent` preloaded near 65535 via 65536 bytes: wraps to 0.
- With `UART_ARB_TIMEOUT_EN`, TIMEOUT=15, UART holds ready high: enable drops after 15 cycles, `timeout_err`=1, IDLE.
